// File: rtl/lsb_mem_ctrl.sv
// rtl/lsb_mem_ctrl.sv - byte-serial RAM/IO responder for LSB loads and ROB committed stores
module lsb_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_out_mem,
  input  logic [5:0]  out_mem_size,
  input  logic        out_mem_signed,
  input  logic [31:0] out_mem_addr,
  output logic        if_get_mem,
  output logic [31:0] data_mem,
  input  logic        if_store,
  input  logic [5:0]  store_size,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_data,
  output logic        store_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

  state_t      r_state;
  logic [2:0]  r_cnt, r_len;
  logic [31:0] r_addr, r_data;
  logic        r_sign;
  logic        r_ld_v, r_ld_sign;
  logic [2:0]  r_ld_len;
  logic [31:0] r_ld_addr;
  logic        r_st_v;
  logic [2:0]  r_st_len;
  logic [31:0] r_st_addr, r_st_data;
  logic        r_get, r_done;
  logic [31:0] r_data_mem;

  function automatic logic [2:0] size_len(input logic [5:0] sz);
    case (sz)
      6'd1:    size_len = 3'd1;
      6'd2:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  // A request is served straight from its pulse when idle, otherwise from its pending slot.
  logic        w_st_v, w_ld_v, w_ld_sign;
  logic [2:0]  w_st_len, w_ld_len;
  logic [31:0] w_st_addr, w_st_data, w_ld_addr;
  assign w_st_v    = r_st_v | if_store;
  assign w_st_len  = r_st_v ? r_st_len  : size_len(store_size);
  assign w_st_addr = r_st_v ? r_st_addr : store_addr;
  assign w_st_data = r_st_v ? r_st_data : store_data;
  assign w_ld_v    = ~clear & (r_ld_v | if_out_mem);
  assign w_ld_len  = r_ld_v ? r_ld_len  : size_len(out_mem_size);
  assign w_ld_addr = r_ld_v ? r_ld_addr : out_mem_addr;
  assign w_ld_sign = r_ld_v ? r_ld_sign : out_mem_signed;

  logic [31:0] w_byte_a, w_shift;
  logic        w_stall, w_last_st;
  assign w_byte_a  = r_addr + {29'd0, r_cnt};
  assign w_shift   = r_data >> {r_cnt[1:0], 3'b000};
  assign w_stall   = io_buffer_full && (w_byte_a >= 32'h0003_0000) && (w_byte_a <= 32'h0003_0007);
  assign w_last_st = (r_cnt == r_len - 3'd1);

  assign mem_wr = rdy && (r_state == S_STORE) && !w_stall;

  // While frozen mid-load, re-present the previous byte address so mem_din still holds byte cnt-1 on resume.
  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    case (r_state)
      S_LOAD:  mem_a = (!rdy && r_cnt != 3'd0) ? w_byte_a - 32'd1 : w_byte_a;
      S_STORE: begin
        mem_a    = w_byte_a;
        mem_dout = w_shift[7:0];
      end
      default: ;
    endcase
  end

  logic [31:0] w_raw, w_ext;
  always_comb begin
    w_raw = r_data;
    case (r_cnt)
      3'd1:    w_raw[7:0]   = mem_din;
      3'd2:    w_raw[15:8]  = mem_din;
      3'd3:    w_raw[23:16] = mem_din;
      3'd4:    w_raw[31:24] = mem_din;
      default: ;
    endcase
    case (r_len)
      3'd1:    w_ext = {{24{r_sign & w_raw[7]}}, w_raw[7:0]};
      3'd2:    w_ext = {{16{r_sign & w_raw[15]}}, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_addr     <= 32'd0;
      r_data     <= 32'd0;
      r_sign     <= 1'b0;
      r_ld_v     <= 1'b0;
      r_ld_sign  <= 1'b0;
      r_ld_len   <= 3'd0;
      r_ld_addr  <= 32'd0;
      r_st_v     <= 1'b0;
      r_st_len   <= 3'd0;
      r_st_addr  <= 32'd0;
      r_st_data  <= 32'd0;
      r_get      <= 1'b0;
      r_done     <= 1'b0;
      r_data_mem <= 32'd0;
    end else if (rdy) begin
      r_get  <= 1'b0;
      r_done <= 1'b0;
      if (clear) begin
        r_ld_v     <= 1'b0;
        r_data_mem <= 32'd0;
      end else if (if_out_mem) begin
        r_ld_v    <= 1'b1;
        r_ld_len  <= size_len(out_mem_size);
        r_ld_sign <= out_mem_signed;
        r_ld_addr <= out_mem_addr;
      end
      if (if_store) begin
        r_st_v    <= 1'b1;
        r_st_len  <= size_len(store_size);
        r_st_addr <= store_addr;
        r_st_data <= store_data;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= 3'd0;
          if (w_st_v) begin
            r_state <= S_STORE;
            r_len   <= w_st_len;
            r_addr  <= w_st_addr;
            r_data  <= w_st_data;
            r_st_v  <= 1'b0;
          end else if (w_ld_v) begin
            r_state <= S_LOAD;
            r_len   <= w_ld_len;
            r_addr  <= w_ld_addr;
            r_sign  <= w_ld_sign;
            r_data  <= 32'd0;
            r_ld_v  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end else begin
            r_data <= w_raw;
            if (r_cnt == r_len) begin
              r_get      <= 1'b1;
              r_data_mem <= w_ext;
              r_state    <= S_IDLE;
              r_cnt      <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        S_STORE: begin
          if (!w_stall) begin
            if (w_last_st) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_cnt   <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_get_mem = r_get & rdy;
  assign store_done = r_done & rdy;
  assign data_mem   = r_data_mem;
endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// tb/tb_lsb_mem_ctrl.sv - vector table, directed corner sequences and random traffic for lsb_mem_ctrl
module tb_lsb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy, clear, if_out_mem, out_mem_signed, if_store, io_buffer_full;
  logic [5:0]  out_mem_size, store_size;
  logic [31:0] out_mem_addr, store_addr, store_data;
  logic        if_get_mem, store_done, mem_wr;
  logic [31:0] data_mem, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din = 8'd0;

  always #5 clk = ~clk;

  lsb_mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .if_out_mem(if_out_mem), .out_mem_size(out_mem_size), .out_mem_signed(out_mem_signed),
    .out_mem_addr(out_mem_addr), .if_get_mem(if_get_mem), .data_mem(data_mem),
    .if_store(if_store), .store_size(store_size), .store_addr(store_addr), .store_data(store_data),
    .store_done(store_done), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  int total = 0, bad = 0, cyc = 0, get_seen = 0, done_seen = 0, both_seen = 0;
  int ld_expect = 0, st_expect = 0;
  logic [7:0] ram [logic [31:0]];
  logic [7:0] shadow [logic [31:0]];
  typedef struct { int cyc; logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog [$];

  typedef struct {
    logic ld; logic [5:0] lsz; logic lsg; logic [31:0] la;
    logic st; logic [5:0] ssz; logic [31:0] sa; logic [31:0] sd;
    int e_llat; logic [31:0] e_ld; int e_slat;
  } vec_t;
  vec_t vt [16];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h11;
      32'h1001: return 8'h22;
      32'h1002: return 8'h33;
      32'h1003: return 8'h84;
      32'h2000: return 8'h80;
      32'h2010: return 8'h7F;
      32'h2011: return 8'hFF;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic int nlen(input logic [5:0] sz);
    return (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
  endfunction

  // Reference memory image: updated from the requested stores, not from bus traffic.
  function automatic void model_store(input logic [5:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nlen(sz); i++) shadow[a + i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] sz, input logic sg, input logic [31:0] a);
    int n;
    logic [31:0] v, ad;
    n = nlen(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      ad = a + i;
      v[8*i +: 8] = shadow.exists(ad) ? shadow[ad] : init_byte(ad);
    end
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  always @(negedge clk) begin
    if (mem_wr) wlog.push_back('{cyc, mem_a, mem_dout});
    if (if_get_mem) get_seen++;
    if (store_done) done_seen++;
    if (if_get_mem && store_done) both_seen++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic ld_en, input logic [5:0] lsz, input logic lsg, input logic [31:0] la,
                        input logic st_en, input logic [5:0] ssz, input logic [31:0] sa, input logic [31:0] sd,
                        output int ld_lat, output logic [31:0] ld_d, output int st_lat);
    int t;
    next_cycle;
    if_out_mem = ld_en; out_mem_size = lsz; out_mem_signed = lsg; out_mem_addr = la;
    if_store = st_en; store_size = ssz; store_addr = sa; store_data = sd;
    ld_lat = -1; st_lat = -1; ld_d = 32'd0;
    next_cycle;
    if_out_mem = 1'b0; if_store = 1'b0;
    t = 1;
    while (t < 80 && ((ld_en && ld_lat < 0) || (st_en && st_lat < 0))) begin
      @(negedge clk);
      if (if_get_mem && ld_lat < 0) begin ld_lat = t; ld_d = data_mem; end
      if (store_done && st_lat < 0) st_lat = t;
      if ((ld_en && ld_lat < 0) || (st_en && st_lat < 0)) begin
        next_cycle;
        t++;
      end
    end
  endtask

  function automatic vec_t ldv(input logic [5:0] sz, input logic sg, input logic [31:0] a, input int lat, input logic [31:0] d);
    vec_t v;
    v = '{default: 0};
    v.ld = 1'b1; v.lsz = sz; v.lsg = sg; v.la = a; v.e_llat = lat; v.e_ld = d;
    return v;
  endfunction

  function automatic vec_t stv(input logic [5:0] sz, input logic [31:0] a, input logic [31:0] d, input int lat);
    vec_t v;
    v = '{default: 0};
    v.st = 1'b1; v.ssz = sz; v.sa = a; v.sd = d; v.e_slat = lat;
    return v;
  endfunction

  initial begin
    int llat, slat, g0, kind, n_l, n_s;
    logic [31:0] ldat, exp_d, sw_word;
    logic [5:0] lsz, ssz;
    logic [31:0] la, sa, sd;
    logic lsg, do_l, do_s;
    logic [5:0] szl [6];
    vec_t v;

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    if_out_mem = 1'b0; out_mem_size = 6'd0; out_mem_signed = 1'b0; out_mem_addr = 32'd0;
    if_store = 1'b0; store_size = 6'd0; store_addr = 32'd0; store_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset if_get_mem", if_get_mem, 0);
    chk("reset store_done", store_done, 0);
    chk("reset data_mem", data_mem, 0);

    vt[0]  = ldv(6'd4, 1'b0, 32'h1000, 6, 32'h84332211);
    vt[1]  = ldv(6'd1, 1'b1, 32'h2000, 3, 32'hFFFFFF80);
    vt[2]  = ldv(6'd1, 1'b0, 32'h2000, 3, 32'h00000080);
    vt[3]  = ldv(6'd2, 1'b1, 32'h2010, 4, 32'hFFFFFF7F);
    vt[4]  = ldv(6'd2, 1'b0, 32'h2010, 4, 32'h0000FF7F);
    vt[5]  = stv(6'd4, 32'h3000, 32'hDEADBEEF, 5);
    vt[6]  = ldv(6'd4, 1'b0, 32'h3000, 6, 32'hDEADBEEF);
    vt[7]  = ldv(6'd4, 1'b1, 32'h1000, 6, 32'h84332211);
    vt[8]  = ldv(6'd3, 1'b1, 32'h1000, 6, 32'h84332211);
    vt[9]  = stv(6'd1, 32'h3001, 32'h00000077, 2);
    vt[10] = ldv(6'd4, 1'b0, 32'h3000, 6, 32'hDEAD77EF);
    v = ldv(6'd1, 1'b1, 32'h2000, 6, 32'hFFFFFFCD);
    v.st = 1'b1; v.ssz = 6'd2; v.sa = 32'h2000; v.sd = 32'h0000ABCD; v.e_slat = 3;
    vt[11] = v;
    vt[12] = stv(6'd2, 32'h2000, 32'h00001234, 3);
    vt[13] = ldv(6'd2, 1'b1, 32'h2000, 4, 32'h00001234);
    vt[14] = stv(6'd0, 32'h2100, 32'h11223344, 5);
    vt[15] = ldv(6'd4, 1'b0, 32'h2100, 6, 32'h11223344);

    for (int i = 0; i < 16; i++) begin
      v = vt[i];
      if (v.st) model_store(v.ssz, v.sa, v.sd);
      run_op(v.ld, v.lsz, v.lsg, v.la, v.st, v.ssz, v.sa, v.sd, llat, ldat, slat);
      if (v.ld) begin
        chk($sformatf("vec%0d load latency", i), llat, v.e_llat);
        chk($sformatf("vec%0d load data", i), ldat, v.e_ld);
        ld_expect++;
      end
      if (v.st) begin
        chk($sformatf("vec%0d store latency", i), slat, v.e_slat);
        st_expect++;
      end
    end

    // SW byte lanes on the bus
    sw_word = 32'hDEADBEEF;
    wlog.delete();
    model_store(6'd4, 32'h3000, sw_word);
    run_op(1'b0, 6'd0, 1'b0, 32'd0, 1'b1, 6'd4, 32'h3000, sw_word, llat, ldat, slat);
    st_expect++;
    chk("sw latency", slat, 5);
    chk("sw write count", wlog.size(), 4);
    for (int k = 0; k < 4 && k < wlog.size(); k++) begin
      chk($sformatf("sw addr %0d", k), wlog[k].a, 32'h3000 + k);
      chk($sformatf("sw byte %0d", k), {24'd0, wlog[k].d}, {24'd0, sw_word[8*k +: 8]});
      chk($sformatf("sw cycle %0d", k), wlog[k].cyc - wlog[0].cyc, k);
    end

    // IO stall: full buffer for 3 cycles
    model_store(6'd1, 32'h30000, 32'h000000A5);
    next_cycle;
    if_store = 1'b1; store_size = 6'd1; store_addr = 32'h30000; store_data = 32'h000000A5; io_buffer_full = 1'b1;
    next_cycle;
    if_store = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("io stall cycle %0d mem_wr", k), mem_wr, 0);
      chk($sformatf("io stall cycle %0d done", k), store_done, 0);
      next_cycle;
    end
    io_buffer_full = 1'b0;
    @(negedge clk);
    chk("io write mem_wr", mem_wr, 1);
    chk("io write addr", mem_a, 32'h30000);
    chk("io write byte", mem_dout, 8'hA5);
    next_cycle;
    @(negedge clk);
    chk("io store_done", store_done, 1);
    st_expect++;

    // clear in the 3rd cycle of a LW
    g0 = get_seen;
    next_cycle;
    if_out_mem = 1'b1; out_mem_size = 6'd4; out_mem_signed = 1'b0; out_mem_addr = 32'h1000;
    next_cycle;
    if_out_mem = 1'b0;
    next_cycle;
    next_cycle;
    clear = 1'b1;
    next_cycle;
    clear = 1'b0;
    repeat (20) next_cycle;
    chk("cleared load no if_get_mem", get_seen - g0, 0);
    run_op(1'b1, 6'd4, 1'b0, 32'h1000, 1'b0, 6'd0, 32'd0, 32'd0, llat, ldat, slat);
    chk("after clear latency", llat, 6);
    chk("after clear data", ldat, 32'h84332211);
    ld_expect++;

    // rdy low for two mid-load cycles
    fork
      run_op(1'b1, 6'd4, 1'b0, 32'h1000, 1'b0, 6'd0, 32'd0, 32'd0, llat, ldat, slat);
      begin
        repeat (3) next_cycle;
        rdy = 1'b0;
        repeat (2) next_cycle;
        rdy = 1'b1;
      end
    join
    chk("rdy stall latency", llat, 8);
    chk("rdy stall data", ldat, 32'h84332211);
    ld_expect++;

    // reset mid-store abandons it
    next_cycle;
    if_store = 1'b1; store_size = 6'd4; store_addr = 32'h2200; store_data = 32'h0;
    next_cycle;
    if_store = 1'b0;
    next_cycle;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async reset mem_wr", mem_wr, 0);
    chk("async reset mem_a", mem_a, 0);
    next_cycle;
    next_cycle;
    rst = 1'b0;
    run_op(1'b1, 6'd4, 1'b0, 32'h1000, 1'b0, 6'd0, 32'd0, 32'd0, llat, ldat, slat);
    chk("after reset latency", llat, 6);
    chk("after reset data", ldat, 32'h84332211);
    ld_expect++;

    szl = '{6'd1, 6'd2, 6'd4, 6'd4, 6'd3, 6'd0};
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      lsz = szl[$urandom_range(0, 5)];
      ssz = szl[$urandom_range(0, 5)];
      lsg = 1'($urandom_range(0, 1));
      la = 32'h400 + $urandom_range(0, 63);
      sa = 32'h400 + $urandom_range(0, 63);
      sd = $urandom;
      n_l = nlen(lsz);
      n_s = nlen(ssz);
      do_l = (kind != 1);
      do_s = (kind != 0);
      if (do_s) model_store(ssz, sa, sd);
      exp_d = model_load(lsz, lsg, la);
      run_op(do_l, lsz, lsg, la, do_s, ssz, sa, sd, llat, ldat, slat);
      if (do_l) begin
        chk($sformatf("rand%0d load data", i), ldat, exp_d);
        chk($sformatf("rand%0d load latency", i), llat, n_l + 2 + (do_s ? n_s + 1 : 0));
        ld_expect++;
      end
      if (do_s) begin
        chk($sformatf("rand%0d store latency", i), slat, n_s + 1);
        st_expect++;
      end
    end

    next_cycle;
    next_cycle;
    chk("if_get_mem pulse count", get_seen, ld_expect);
    chk("store_done pulse count", done_seen, st_expect);
    chk("get/done overlap", both_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
